// File: rtl/kontroler_przerwan_if.sv
// ---------------------------------------------------------------------------
// kontroler_przerwan_if
//
// Purpose: bundles the signals exchanged between the interrupt controller and
// the instruction decoder (ID): control strobes (EI / DI / RETI), register
// writes for the mask and trigger-mode registers, and the vectored
// request/acknowledge handshake.
//
// Modports:
//   master - instruction-decoder side: drives strobes, write data and ack,
//            observes the request and its vector.
//   slave  - controller side: the mirror image of master.
//
// Signals:
//   int_enable      EI: set global enable
//   int_disable     DI: clear global enable
//   int_eoi         RETI: end of service, one-cycle pulse
//   wr_maska        write strobe for the mask register
//   wr_tryb         write strobe for the trigger-mode register
//   dane_in         write data for mask / mode registers
//   przerwanie      interrupt request to the ID
//   przerwanie_ack  ID accepts the request at an instruction boundary
//   int_vector      jump address of the requested channel
// ---------------------------------------------------------------------------
interface kontroler_przerwan_if #(
  parameter int N_ZRODEL = 4,
  parameter int W_WEKTOR = 8
);
  logic                int_enable;
  logic                int_disable;
  logic                int_eoi;
  logic                wr_maska;
  logic                wr_tryb;
  logic [N_ZRODEL-1:0] dane_in;
  logic                przerwanie;
  logic                przerwanie_ack;
  logic [W_WEKTOR-1:0] int_vector;

  modport master (
    output int_enable,
    output int_disable,
    output int_eoi,
    output wr_maska,
    output wr_tryb,
    output dane_in,
    output przerwanie_ack,
    input  przerwanie,
    input  int_vector
  );

  modport slave (
    input  int_enable,
    input  int_disable,
    input  int_eoi,
    input  wr_maska,
    input  wr_tryb,
    input  dane_in,
    input  przerwanie_ack,
    output przerwanie,
    output int_vector
  );
endinterface

// File: rtl/kontroler_przerwan.sv
// ---------------------------------------------------------------------------
// kontroler_przerwan
//
// Purpose: multi-channel vectored interrupt controller for the 8-bit core.
// Raw request lines are synchronised, latched as edge- or level-triggered
// pending bits, filtered by a per-channel mask, the global enable and the
// in-service set (nesting), and the highest-priority survivor (lowest index)
// is presented to the instruction decoder as a vector under a
// request/acknowledge handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   bus          kontroler_przerwan_if.slave (strobes, register writes,
//                request/ack handshake, vector)
//   irq_in       raw request lines, asynchronous to clk
//   oczekujace   pending register
//   w_obsludze   in-service register
//   globalne_en  current global enable
// ---------------------------------------------------------------------------
module kontroler_przerwan #(
  parameter int                  N_ZRODEL     = 4,
  parameter int                  W_WEKTOR     = 8,
  parameter logic [W_WEKTOR-1:0] BAZA_WEKTORA = 'h02,
  parameter int                  KROK_WEKTORA = 2,
  parameter logic [N_ZRODEL-1:0] TRYB_RESET   = '1
) (
  input  logic                clk,
  input  logic                rst,
  kontroler_przerwan_if.slave bus,
  input  logic [N_ZRODEL-1:0] irq_in,
  output logic [N_ZRODEL-1:0] oczekujace,
  output logic [N_ZRODEL-1:0] w_obsludze,
  output logic                globalne_en
);

  localparam int IW = (N_ZRODEL > 1) ? $clog2(N_ZRODEL) : 1;

  typedef enum logic {
    BEZCZYNNY,
    ZADANIE
  } stan_t;

  // Vector of channel idx: base + idx*step, wrapping at the vector width.
  function automatic logic [W_WEKTOR-1:0] wektor(input logic [IW-1:0] idx);
    logic [31:0] przesuniecie;
    przesuniecie = 32'(idx) * 32'(KROK_WEKTORA);
    return BAZA_WEKTORA + przesuniecie[W_WEKTOR-1:0];
  endfunction

  // -------------------------------------------------------------------------
  // Input conditioning: two synchroniser stages plus one edge-detect stage.
  // -------------------------------------------------------------------------
  logic [N_ZRODEL-1:0] sync1, sync2, sync3;
  logic [N_ZRODEL-1:0] narastanie;

  // NOTE: every flop here, the synchroniser chain included, has an explicit
  // reset value so the first post-reset edge cannot be mistaken for a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      // NOTE: non-blocking assignments make the three stages shift together
      // instead of collapsing into one register.
      sync1 <= irq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign narastanie = sync2 & ~sync3;

  // -------------------------------------------------------------------------
  // Configuration registers.
  // -------------------------------------------------------------------------
  logic [N_ZRODEL-1:0] maska;
  logic [N_ZRODEL-1:0] tryb;   // 1 = rising edge, 0 = level high

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maska <= '0;
      tryb  <= TRYB_RESET;
    end else begin
      if (bus.wr_maska) maska <= bus.dane_in;
      if (bus.wr_tryb)  tryb  <= bus.dane_in;
    end
  end

  // -------------------------------------------------------------------------
  // Eligibility and priority selection (all from current register values).
  // -------------------------------------------------------------------------
  logic [N_ZRODEL-1:0] dozwolone;      // strictly higher priority than any in-service channel
  logic                blokada;
  logic [N_ZRODEL-1:0] kwalifikowane;
  logic [IW-1:0]       wybrany;
  logic                jest_kandydat;

  // NOTE: each variable gets a default before the loop so that no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    dozwolone = '0;
    blokada   = 1'b0;
    for (int i = 0; i < N_ZRODEL; i++) begin
      blokada      = blokada | w_obsludze[i];
      dozwolone[i] = ~blokada;
    end
  end

  assign kwalifikowane = oczekujace & maska & dozwolone & {N_ZRODEL{globalne_en}};

  // Scan from the bottom priority upward so the lowest index wins.
  always_comb begin
    wybrany       = '0;
    jest_kandydat = 1'b0;
    for (int i = N_ZRODEL - 1; i >= 0; i--) begin
      if (kwalifikowane[i]) begin
        wybrany       = IW'(i);
        jest_kandydat = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request/acknowledge FSM.
  // -------------------------------------------------------------------------
  stan_t         stan;
  logic [IW-1:0] aktywny;       // channel currently (or last) requested
  logic          ack_przyjete;
  logic          maska_zdjeta;
  logic          wycofanie;

  assign ack_przyjete = (stan == ZADANIE) && bus.przerwanie_ack;
  assign maska_zdjeta = bus.wr_maska && !bus.dane_in[aktywny];
  // Ack wins over withdrawal when both arrive in the same cycle.
  assign wycofanie    = (stan == ZADANIE) && !bus.przerwanie_ack &&
                        (bus.int_disable || maska_zdjeta);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stan           <= BEZCZYNNY;
      bus.przerwanie <= 1'b0;
      bus.int_vector <= BAZA_WEKTORA;
      aktywny        <= '0;
    end else begin
      case (stan)
        BEZCZYNNY: begin
          if (jest_kandydat) begin
            stan           <= ZADANIE;
            bus.przerwanie <= 1'b1;
            bus.int_vector <= wektor(wybrany);
            aktywny        <= wybrany;
          end
        end
        ZADANIE: begin
          // Vector stays frozen; later arrivals wait for the return to idle.
          if (ack_przyjete || wycofanie) begin
            stan           <= BEZCZYNNY;
            bus.przerwanie <= 1'b0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pending register.
  // -------------------------------------------------------------------------
  logic [N_ZRODEL-1:0] oczekujace_nast;

  always_comb begin
    oczekujace_nast = oczekujace;
    for (int i = 0; i < N_ZRODEL; i++) begin
      if (bus.wr_tryb && (bus.dane_in[i] != tryb[i])) begin
        // A mode change discards whatever was latched under the old mode.
        oczekujace_nast[i] = 1'b0;
      end else if (!tryb[i]) begin
        oczekujace_nast[i] = sync2[i];
      end else if (narastanie[i]) begin
        // A fresh edge is kept even if the channel is acknowledged this cycle.
        oczekujace_nast[i] = 1'b1;
      end else if (ack_przyjete && (aktywny == IW'(i))) begin
        oczekujace_nast[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oczekujace <= '0;
    else     oczekujace <= oczekujace_nast;
  end

  // -------------------------------------------------------------------------
  // In-service register and global enable.
  // -------------------------------------------------------------------------
  logic [N_ZRODEL-1:0] najnizszy;      // one-hot lowest set bit of w_obsludze
  logic [N_ZRODEL-1:0] w_obsludze_nast;

  assign najnizszy = w_obsludze & (~w_obsludze + N_ZRODEL'(1));

  always_comb begin
    w_obsludze_nast = w_obsludze;
    if (bus.int_eoi)  w_obsludze_nast = w_obsludze_nast & ~najnizszy;
    if (ack_przyjete) w_obsludze_nast = w_obsludze_nast | (N_ZRODEL'(1) << aktywny);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_obsludze  <= '0;
      globalne_en <= 1'b0;
    end else begin
      w_obsludze <= w_obsludze_nast;
      if (ack_przyjete)                        globalne_en <= 1'b0;
      else if (bus.int_disable)                globalne_en <= 1'b0;
      else if (bus.int_eoi || bus.int_enable)  globalne_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kontroler_przerwan.sv
// ---------------------------------------------------------------------------
// tb_kontroler_przerwan
//
// Bench for kontroler_przerwan (4 channels, 8-bit vectors, base 8'h02,
// step 2). Directed scenarios check fixed expected values; a randomized
// phase compares every output each cycle against a behavioural model that
// works from the request history and the controller's rules directly.
// ---------------------------------------------------------------------------
module tb_kontroler_przerwan;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_in;
  logic [N-1:0] oczekujace;
  logic [N-1:0] w_obsludze;
  logic         globalne_en;

  kontroler_przerwan_if #(.N_ZRODEL(N), .W_WEKTOR(W)) bus ();

  kontroler_przerwan #(
    .N_ZRODEL    (N),
    .W_WEKTOR    (W),
    .BAZA_WEKTORA(8'h02),
    .KROK_WEKTORA(2),
    .TRYB_RESET  (4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .irq_in     (irq_in),
    .oczekujace (oczekujace),
    .w_obsludze (w_obsludze),
    .globalne_en(globalne_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------------
  bit [N-1:0] m_pend, m_mask, m_mode, m_ws;
  bit         m_en, m_req;
  int         m_idx;
  bit [W-1:0] m_vec;
  // Values of irq_in sampled 1, 2 and 3 edges before the current one.
  bit [N-1:0] m_h1, m_h2, m_h3;

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = 4'hF; m_ws = '0;
    m_en = 1'b0; m_req = 1'b0; m_idx = 0; m_vec = 8'h02;
    m_h1 = '0; m_h2 = '0; m_h3 = '0;
  endtask

  task automatic model_update();
    int         lowest, win;
    bit         ack;
    bit [N-1:0] rise, n_pend, n_ws;
    bit         n_en;
    lowest = N;
    for (int i = N - 1; i >= 0; i--) if (m_ws[i]) lowest = i;
    win = -1;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && m_mask[i] && m_en && i < lowest) win = i;
    ack = m_req && bus.przerwanie_ack;

    // Pending: the synchronised level is the line as sampled two edges ago.
    rise   = m_h2 & ~m_h3;
    n_pend = m_pend;
    for (int i = 0; i < N; i++) begin
      if (bus.wr_tryb && bus.dane_in[i] != m_mode[i]) n_pend[i] = 1'b0;
      else if (!m_mode[i])                           n_pend[i] = m_h2[i];
      else if (rise[i])                              n_pend[i] = 1'b1;
      else if (ack && m_idx == i)                    n_pend[i] = 1'b0;
    end

    n_ws = m_ws;
    if (bus.int_eoi && lowest < N) n_ws[lowest] = 1'b0;
    if (ack) n_ws[m_idx] = 1'b1;

    n_en = m_en;
    if (ack)                                  n_en = 1'b0;
    else if (bus.int_disable)                 n_en = 1'b0;
    else if (bus.int_eoi || bus.int_enable)   n_en = 1'b1;

    if (!m_req) begin
      if (win >= 0) begin
        m_req = 1'b1;
        m_idx = win;
        m_vec = W'((2 + win * 2) % 256);
      end
    end else if (ack) begin
      m_req = 1'b0;
    end else if (bus.int_disable || (bus.wr_maska && !bus.dane_in[m_idx])) begin
      m_req = 1'b0;
    end

    if (bus.wr_maska) m_mask = bus.dane_in;
    if (bus.wr_tryb)  m_mode = bus.dane_in;
    m_pend = n_pend; m_ws = n_ws; m_en = n_en;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq_in;
  endtask

  // ------------------------------------------------------------------------
  // Stimulus helpers (inputs change only at the falling edge)
  // ------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    irq_in = '0;
    bus.int_enable = 1'b0; bus.int_disable = 1'b0; bus.int_eoi = 1'b0;
    bus.wr_maska = 1'b0; bus.wr_tryb = 1'b0; bus.dane_in = '0;
    bus.przerwanie_ack = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_mask(input bit [N-1:0] v);
    bus.dane_in = v; bus.wr_maska = 1'b1; step(); bus.wr_maska = 1'b0;
  endtask

  task automatic set_mode(input bit [N-1:0] v);
    bus.dane_in = v; bus.wr_tryb = 1'b1; step(); bus.wr_tryb = 1'b0;
  endtask

  task automatic pulse_ei();  bus.int_enable = 1'b1;     step(); bus.int_enable = 1'b0;     endtask
  task automatic pulse_eoi(); bus.int_eoi = 1'b1;        step(); bus.int_eoi = 1'b0;        endtask
  task automatic pulse_ack(); bus.przerwanie_ack = 1'b1; step(); bus.przerwanie_ack = 1'b0; endtask

  task automatic pulse_irq(input bit [N-1:0] v);
    irq_in = v; step(); irq_in = '0;
  endtask

  task automatic wait_przerwanie(input int budget, output bit ok);
    ok = bus.przerwanie;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = bus.przerwanie;
    end
  endtask

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  task automatic test_reset();
    reset_dut();
    checks++; if (bus.przerwanie !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.przerwanie); end
    checks++; if (bus.int_vector !== 8'h02) begin errors++; $display("FAIL reset_vec: got %h want 02", bus.int_vector); end
    checks++; if (oczekujace !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b want 0000", oczekujace); end
    checks++; if (w_obsludze !== 4'b0000) begin errors++; $display("FAIL reset_ws: got %b want 0000", w_obsludze); end
    checks++; if (globalne_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", globalne_en); end
  endtask

  task automatic test_single_edge();
    reset_dut();
    set_mask(4'b0010);
    pulse_ei();
    pulse_irq(4'b0010);          // edge k
    step();                      // k+1
    step();                      // k+2
    checks++; if (oczekujace !== 4'b0010) begin errors++; $display("FAIL single_pend_lat: got %b want 0010", oczekujace); end
    checks++; if (bus.przerwanie !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", bus.przerwanie); end
    step();                      // k+3
    checks++; if (bus.przerwanie !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bus.przerwanie); end
    checks++; if (bus.int_vector !== 8'h04) begin errors++; $display("FAIL single_vec: got %h want 04", bus.int_vector); end
    pulse_ack();
    checks++; if (bus.przerwanie !== 1'b0) begin errors++; $display("FAIL single_ack_req: got %b want 0", bus.przerwanie); end
    checks++; if (w_obsludze !== 4'b0010) begin errors++; $display("FAIL single_ws: got %b want 0010", w_obsludze); end
    checks++; if (globalne_en !== 1'b0) begin errors++; $display("FAIL single_en: got %b want 0", globalne_en); end
    checks++; if (oczekujace !== 4'b0000) begin errors++; $display("FAIL single_pend: got %b want 0000", oczekujace); end
    pulse_eoi();
    checks++; if (w_obsludze !== 4'b0000 || globalne_en !== 1'b1) begin
      errors++; $display("FAIL single_eoi: got ws=%b en=%b want ws=0000 en=1", w_obsludze, globalne_en); end
  endtask

  task automatic test_priority();
    bit ok;
    reset_dut();
    set_mask(4'b1111);
    pulse_ei();
    pulse_irq(4'b1001);
    wait_przerwanie(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_first_timeout: przerwanie=%b want 1", bus.przerwanie); end
    checks++; if (bus.int_vector !== 8'h02) begin errors++; $display("FAIL prio_first_vec: got %h want 02", bus.int_vector); end
    checks++; if (oczekujace !== 4'b1001) begin errors++; $display("FAIL prio_pend: got %b want 1001", oczekujace); end
    pulse_ack();
    checks++; if (oczekujace !== 4'b1000 || w_obsludze !== 4'b0001) begin
      errors++; $display("FAIL prio_after_ack: got pend=%b ws=%b want 1000/0001", oczekujace, w_obsludze); end
    pulse_eoi();
    pulse_ei();
    wait_przerwanie(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_second_timeout: przerwanie=%b want 1", bus.przerwanie); end
    checks++; if (bus.int_vector !== 8'h08) begin errors++; $display("FAIL prio_second_vec: got %h want 08", bus.int_vector); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_nesting();
    bit ok;
    reset_dut();
    set_mask(4'b1111);
    pulse_ei();
    pulse_irq(4'b0100);
    wait_przerwanie(10, ok);
    checks++; if (!ok || bus.int_vector !== 8'h06) begin
      errors++; $display("FAIL nest_ch2: got req=%b vec=%h want 1/06", bus.przerwanie, bus.int_vector); end
    pulse_ack();
    pulse_ei();
    pulse_irq(4'b1001);
    wait_przerwanie(10, ok);
    checks++; if (!ok || bus.int_vector !== 8'h02) begin
      errors++; $display("FAIL nest_ch0: got req=%b vec=%h want 1/02", bus.przerwanie, bus.int_vector); end
    pulse_ack();
    checks++; if (w_obsludze !== 4'b0101) begin errors++; $display("FAIL nest_ws: got %b want 0101", w_obsludze); end
    pulse_ei();
    for (int c = 0; c < 6; c++) step();
    checks++; if (bus.przerwanie !== 1'b0 || oczekujace[3] !== 1'b1) begin
      errors++; $display("FAIL nest_block1: got req=%b pend=%b want 0/1xxx", bus.przerwanie, oczekujace); end
    pulse_eoi();
    checks++; if (w_obsludze !== 4'b0100) begin errors++; $display("FAIL nest_eoi_order: got %b want 0100", w_obsludze); end
    for (int c = 0; c < 6; c++) step();
    checks++; if (bus.przerwanie !== 1'b0) begin errors++; $display("FAIL nest_block2: got %b want 0", bus.przerwanie); end
    pulse_eoi();
    wait_przerwanie(10, ok);
    checks++; if (!ok || bus.int_vector !== 8'h08) begin
      errors++; $display("FAIL nest_ch3: got req=%b vec=%h want 1/08", bus.przerwanie, bus.int_vector); end
    pulse_ack();
    pulse_eoi();
  endtask

  task automatic test_level();
    bit ok;
    reset_dut();
    set_mode(4'b1110);
    set_mask(4'b1111);
    pulse_ei();
    irq_in = 4'b0001;
    for (int r = 0; r < 3; r++) begin
      wait_przerwanie(10, ok);
      checks++; if (!ok || bus.int_vector !== 8'h02) begin
        errors++; $display("FAIL level_req%0d: got req=%b vec=%h want 1/02", r, bus.przerwanie, bus.int_vector); end
      pulse_ack();
      checks++; if (oczekujace[0] !== 1'b1) begin errors++; $display("FAIL level_hold%0d: got %b want 1", r, oczekujace[0]); end
      pulse_eoi();
    end
    wait_przerwanie(10, ok);
    pulse_ack();
    irq_in = 4'b0000;
    step(); step(); step();
    checks++; if (oczekujace[0] !== 1'b0) begin errors++; $display("FAIL level_drop: got %b want 0", oczekujace[0]); end
    pulse_eoi();
    for (int c = 0; c < 4; c++) step();
    checks++; if (bus.przerwanie !== 1'b0) begin errors++; $display("FAIL level_quiet: got %b want 0", bus.przerwanie); end
  endtask

  task automatic test_withdraw();
    bit ok;
    reset_dut();
    set_mask(4'b1111);
    pulse_ei();
    pulse_irq(4'b0010);
    wait_przerwanie(10, ok);
    bus.int_disable = 1'b1; step(); bus.int_disable = 1'b0;
    checks++; if (bus.przerwanie !== 1'b0 || oczekujace !== 4'b0010 || w_obsludze !== 4'b0000 || globalne_en !== 1'b0) begin
      errors++; $display("FAIL withdraw_di: got req=%b pend=%b ws=%b en=%b want 0/0010/0000/0", bus.przerwanie, oczekujace, w_obsludze, globalne_en); end
    pulse_ei();
    wait_przerwanie(10, ok);
    checks++; if (!ok || bus.int_vector !== 8'h04) begin
      errors++; $display("FAIL withdraw_rereq: got req=%b vec=%h want 1/04", bus.przerwanie, bus.int_vector); end
    bus.int_disable = 1'b1; bus.przerwanie_ack = 1'b1; step();
    bus.int_disable = 1'b0; bus.przerwanie_ack = 1'b0;
    checks++; if (w_obsludze !== 4'b0010 || oczekujace !== 4'b0000 || globalne_en !== 1'b0 || bus.przerwanie !== 1'b0) begin
      errors++; $display("FAIL withdraw_ack_di: got ws=%b pend=%b en=%b req=%b want 0010/0000/0/0", w_obsludze, oczekujace, globalne_en, bus.przerwanie); end
  endtask

  task automatic test_masked_latch_and_reset();
    bit ok;
    reset_dut();
    pulse_ei();
    pulse_irq(4'b1000);
    for (int c = 0; c < 5; c++) step();
    checks++; if (oczekujace !== 4'b1000 || bus.przerwanie !== 1'b0) begin
      errors++; $display("FAIL masked_latch: got pend=%b req=%b want 1000/0", oczekujace, bus.przerwanie); end
    set_mask(4'b1000);
    wait_przerwanie(10, ok);
    checks++; if (!ok || bus.int_vector !== 8'h08) begin
      errors++; $display("FAIL masked_unmask: got req=%b vec=%h want 1/08", bus.przerwanie, bus.int_vector); end
    set_mask(4'b0000);
    checks++; if (bus.przerwanie !== 1'b0 || oczekujace !== 4'b1000) begin
      errors++; $display("FAIL mask_withdraw: got req=%b pend=%b want 0/1000", bus.przerwanie, oczekujace); end
    set_mask(4'b1000);
    wait_przerwanie(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_rereq: przerwanie=%b want 1", bus.przerwanie); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.przerwanie !== 1'b0 || bus.int_vector !== 8'h02 || oczekujace !== 4'b0000 || w_obsludze !== 4'b0000 || globalne_en !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%b vec=%h pend=%b ws=%b en=%b want 0/02/0000/0000/0", bus.przerwanie, bus.int_vector, oczekujace, w_obsludze, globalne_en); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    reset_dut();
    set_mask(4'b1111);
    pulse_ei();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 6) == 0) irq_in[i] = ~irq_in[i];
      bus.przerwanie_ack = ($urandom_range(0, 2) == 0);
      bus.int_enable     = ($urandom_range(0, 5) == 0);
      bus.int_disable    = ($urandom_range(0, 15) == 0);
      bus.int_eoi        = ($urandom_range(0, 6) == 0);
      bus.wr_maska       = ($urandom_range(0, 19) == 0);
      bus.wr_tryb        = ($urandom_range(0, 39) == 0);
      bus.dane_in        = N'($urandom);
      step();
      checks++; if (bus.przerwanie !== m_req) begin errors++; $display("FAIL rnd_req@%0d: got %b want %b", c, bus.przerwanie, m_req); end
      checks++; if (bus.int_vector !== m_vec) begin errors++; $display("FAIL rnd_vec@%0d: got %h want %h", c, bus.int_vector, m_vec); end
      checks++; if (oczekujace !== m_pend) begin errors++; $display("FAIL rnd_pend@%0d: got %b want %b", c, oczekujace, m_pend); end
      checks++; if (w_obsludze !== m_ws) begin errors++; $display("FAIL rnd_ws@%0d: got %b want %b", c, w_obsludze, m_ws); end
      checks++; if (globalne_en !== m_en) begin errors++; $display("FAIL rnd_en@%0d: got %b want %b", c, globalne_en, m_en); end
    end
    clear_inputs();
  endtask

  // ------------------------------------------------------------------------
  // Sequence
  // ------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_edge();
    test_priority();
    test_nesting();
    test_level();
    test_withdraw();
    test_masked_latch_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
